spike_out_arbiter: RTL and testbench

Round-robin scheduler that shares one output serializer between `N_REQ` spike-word producers. It sits between the core output buffers and the chip's 16-bit-to-`IO_WIDTH` output serializer. It grants one 16-bit spike word at a time and drives the serializer's load strobe and data. Loads are spaced so that no word is ever overwritten mid-serialization. All arbitration is suspended while the chip is in bypass (daisy-chain) mode.

---
 rtl/spike_io_pkg.sv | 17 +
 rtl/rr_pick.sv | 40 ++++
 rtl/spike_out_arbiter.sv | 113 +++++++++++
 tb/tb_spike_out_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/spike_io_pkg.sv
// Constants, FSM state type and beat-count helper shared by the spike output
// arbiter and the output serializer.
package spike_io_pkg;

  localparam int unsigned SPIKE_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  // Serializer output cycles needed to ship one spike word.
  function automatic int unsigned beats(input int unsigned io_width);
    return SPIKE_W / io_width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational wrap-around priority picker: first asserted request at or
// above ptr, searching upward modulo N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic                     any
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned SUM_W = PTR_W + 1;

  logic             found;
  logic [SUM_W-1:0] sum;
  logic [PTR_W-1:0] idx;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(N_REQ)) begin
        sum = sum - SUM_W'(N_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spike_out_arbiter.sv
// Round-robin scheduler feeding one 16-bit output serializer from N_REQ producers.
// Optional SPIKE_ARB_ZERO_SKIP_EN: all-zero words are consumed without a load.
module spike_out_arbiter
  import spike_io_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned IO_WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RSTB,
  input  logic                     BP,
  input  logic [N_REQ-1:0]         REQ_VALID,
  input  logic [SPIKE_W*N_REQ-1:0] REQ_SPIKE,
  output logic [N_REQ-1:0]         REQ_READY,
  output logic                     SER_LOAD,
  output logic [SPIKE_W-1:0]       SER_SPIKE,
  output logic                     BUSY,
  output logic [15:0]              STAT_WORDS
);

  localparam int unsigned BEATS = beats(IO_WIDTH);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W = $clog2(N_REQ);

  arb_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   ptr;
  logic [N_REQ-1:0]   pick_gnt;
  logic               pick_any;
  logic               grant;
  logic               do_load;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   ptr_inc;
  logic [SPIKE_W-1:0] win_word;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (REQ_VALID),
    .ptr (ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // Grants only outside bypass and once the previous word's spacing window closed.
  assign grant     = RSTB && !BP && (state == IDLE || cnt == '0) && pick_any;
  assign REQ_READY = grant ? pick_gnt : '0;

  // Winner index and its word.
  always_comb begin
    win      = '0;
    win_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        win      = PTR_W'(i);
        win_word = REQ_SPIKE[i*SPIKE_W +: SPIKE_W];
      end
    end
  end

  assign ptr_inc = (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;

`ifdef SPIKE_ARB_ZERO_SKIP_EN
  assign do_load = grant && (win_word != '0);
`else
  assign do_load = grant;
`endif

  // Arbitration FSM, spacing counter and serializer-facing registers.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      SER_LOAD   <= 1'b0;
      SER_SPIKE  <= '0;
      BUSY       <= 1'b0;
      STAT_WORDS <= '0;
    end else begin
      SER_LOAD <= do_load;
      if (grant) begin
        ptr <= ptr_inc;
      end
      if (do_load) begin
        SER_SPIKE <= win_word;
        if (STAT_WORDS != 16'hFFFF) begin
          STAT_WORDS <= STAT_WORDS + 16'd1;
        end
      end
      if (BP) begin
        state <= IDLE;
        cnt   <= '0;
        BUSY  <= 1'b0;
      end else if (do_load) begin
        if (BEATS > 1) begin
          state <= SEND;
          cnt   <= CNT_W'(BEATS - 1);
          BUSY  <= 1'b1;
        end else begin
          state <= IDLE;
          cnt   <= '0;
          BUSY  <= 1'b0;
        end
      end else if (state == SEND) begin
        if (cnt != '0) begin
          cnt  <= cnt - 1'b1;
          BUSY <= (cnt != CNT_W'(1));
        end else if (!pick_any) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_out_arbiter.sv
// Scoreboard bench for spike_out_arbiter: randomized requesters and bypass
// against a cycle-level round-robin reference model.
module tb_spike_out_arbiter;

  localparam int N    = 4;
  localparam int IO_W = 8;
  localparam int B    = 16 / IO_W;
  localparam int NCYC = 3000;

`ifdef SPIKE_ARB_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic          CLK  = 1'b0;
  logic          RSTB = 1'b0;
  logic          BP   = 1'b0;
  logic [N-1:0]  REQ_VALID;
  logic [16*N-1:0] REQ_SPIKE;
  logic [N-1:0]  REQ_READY;
  logic          SER_LOAD;
  logic [15:0]   SER_SPIKE;
  logic          BUSY;
  logic [15:0]   STAT_WORDS;

  spike_out_arbiter #(.N_REQ(N), .IO_WIDTH(IO_W)) dut (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .BP         (BP),
    .REQ_VALID  (REQ_VALID),
    .REQ_SPIKE  (REQ_SPIKE),
    .REQ_READY  (REQ_READY),
    .SER_LOAD   (SER_LOAD),
    .SER_SPIKE  (SER_SPIKE),
    .BUSY       (BUSY),
    .STAT_WORDS (STAT_WORDS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] word;
    int          stat;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  bit          rq_v[N];
  logic [15:0] rq_w[N];
  int          m_ptr, m_next_ok, m_stat, bp_left;
  bit          last_load = 1'b0;
  bit          rst_done  = 1'b0;
  bit          post_rst  = 1'b0;
  int          open_gnt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      REQ_VALID[i]          = rq_v[i];
      REQ_SPIKE[16*i +: 16] = rq_w[i];
    end
  endtask

  // Reference: grant allowed once the spacing window is over; bypass closes it.
  task automatic evaluate(input int c);
    int win;
    logic [N-1:0] exp_rdy;
    win = -1;
    chk("busy", 32'(BUSY), 32'(c < m_next_ok));
    if (!BP && c >= m_next_ok) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (win < 0 && rq_v[idx]) win = idx;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", 32'(REQ_READY), 32'(exp_rdy));
    for (int k = 0; k < 5; k++) begin
      if (c == 2 * k) chk("open_grant", 32'(REQ_READY), 32'(1 << open_gnt[k]));
    end
    if (c == 9)  chk("open_stat", 32'(STAT_WORDS), 32'd5);
    if (c == 10) chk("grant_before_bp", 32'(REQ_READY), 32'h2);
    if (c == 21) chk("grant_after_bp", 32'(REQ_READY), 32'h4);
    if (post_rst) begin
      chk("first_after_rst", 32'(REQ_READY), 32'h1);
      post_rst = 1'b0;
    end
    if (BP) m_next_ok = c + 1;
    last_load = 1'b0;
    if (win >= 0) begin
      m_ptr    = (win + 1) % N;
      rq_v[win] = 1'b0;
      if (!(ZSKIP && rq_w[win] == 16'h0000)) begin
        if (m_stat < 65535) m_stat++;
        sb.push_back('{rq_w[win], m_stat, c + 1});
        m_next_ok = c + B;
        last_load = 1'b1;
      end
    end
  endtask

  // Inputs for cycle nc: opening phase keeps everyone requesting, then random.
  task automatic stimulate(input int nc);
    for (int i = 0; i < N; i++) begin
      if (!rq_v[i] && (nc < 22 || $urandom_range(0, 1) == 1)) begin
        rq_v[i] = 1'b1;
        if (nc >= 22 && $urandom_range(0, 7) == 0) rq_w[i] = 16'h0000;
        else rq_w[i] = 16'($urandom_range(1, 65535));
      end
    end
    if (nc < 22) begin
      BP = (nc >= 11 && nc <= 20);
    end else begin
      if (bp_left > 0) bp_left--;
      else if ($urandom_range(0, 39) == 0) bp_left = $urandom_range(1, 12);
      BP = (bp_left > 0);
    end
    drive_inputs();
  endtask

  // Asynchronous reset in the middle of a word's spacing window.
  task automatic mid_reset(input int nc);
    chk("busy_pre_rst", 32'(BUSY), 32'(nc < m_next_ok));
    chk("load_pre_rst", 32'(SER_LOAD), 32'(last_load));
    for (int i = 0; i < N; i++) begin
      if (!rq_v[i]) begin
        rq_v[i] = 1'b1;
        rq_w[i] = 16'($urandom_range(1, 65535));
      end
    end
    bp_left = 0;
    BP      = 1'b0;
    drive_inputs();
    RSTB = 1'b0;
    #1;
    chk("rst_ready", 32'(REQ_READY), 32'h0);
    chk("rst_load", 32'(SER_LOAD), 32'h0);
    chk("rst_spike", 32'(SER_SPIKE), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_stat", 32'(STAT_WORDS), 32'h0);
    sb.delete();
    m_ptr     = 0;
    m_next_ok = 0;
    m_stat    = 0;
    #1;
    RSTB     = 1'b1;
    rst_done = 1'b1;
    post_rst = 1'b1;
  endtask

  // Driver and reference model.
  initial begin
    open_gnt = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      rq_v[i] = 1'b1;
      rq_w[i] = 16'($urandom_range(1, 65535));
    end
    drive_inputs();
    m_ptr = 0; m_next_ok = 0; m_stat = 0; bp_left = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("init_ready", 32'(REQ_READY), 32'h0);
    chk("init_load", 32'(SER_LOAD), 32'h0);
    chk("init_spike", 32'(SER_SPIKE), 32'h0);
    chk("init_busy", 32'(BUSY), 32'h0);
    chk("init_stat", 32'(STAT_WORDS), 32'h0);
    RSTB = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      @(negedge CLK);
      evaluate(c);
      @(posedge CLK);
      #1;
      cyc = c + 1;
      stimulate(c + 1);
      if (!rst_done && c > 400 && last_load) mid_reset(c + 1);
    end
    cyc = NCYC;
    for (int i = 0; i < N; i++) rq_v[i] = 1'b0;
    BP = 1'b0;
    drive_inputs();
    @(negedge CLK);
    @(posedge CLK);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    chk("reset_exercised", 32'(rst_done), 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: every serializer load must match the oldest expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RSTB) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          checks++;
          failures++;
          $display("FAIL load_missing cyc=%0d actual=none required=%h due=%0d", cyc, e.word, e.due);
        end
        if (SER_LOAD) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL load_unexpected cyc=%0d actual=%h required=none", cyc, SER_SPIKE);
          end else begin
            e = sb.pop_front();
            chk("ser_spike", 32'(SER_SPIKE), 32'(e.word));
            chk("stat_words", 32'(STAT_WORDS), 32'(e.stat));
            chk("load_cycle", 32'(cyc), 32'(e.due));
          end
        end
      end
    end
  end

endmodule
